// File: rtl/lc4_dx_stage.sv
// LC4 decode-to-execute stage: regfile read select, W->D bypass, load-use detection, D/X register.
// Ports: D-stage decode inputs, regfile read ports, W write-back tap, flush/stall, registered X outputs.
module lc4_dx_stage #(
  parameter int n     = 16,
  parameter int ctl_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic [n-1:0]     i_d_pc,
  input  logic [n-1:0]     i_d_insn,
  input  logic             i_d_valid,
  input  logic [1:0]       i_d_stall_code,
  input  logic [2:0]       i_d_rs_sel,
  input  logic [2:0]       i_d_rt_sel,
  input  logic [2:0]       i_d_rd_sel,
  input  logic             i_d_rs_re,
  input  logic             i_d_rt_re,
  input  logic             i_d_rd_we,
  input  logic             i_d_is_load,
  input  logic             i_d_is_store,
  input  logic             i_d_is_branch,
  input  logic [ctl_w-1:0] i_d_ctl,
  output logic [2:0]       o_rs_sel,
  output logic [2:0]       o_rt_sel,
  input  logic [n-1:0]     i_rs_data,
  input  logic [n-1:0]     i_rt_data,
  input  logic [2:0]       i_w_rd_sel,
  input  logic             i_w_rd_we,
  input  logic [n-1:0]     i_w_wdata,
  input  logic             i_flush,
  output logic             o_stall,
  output logic [n-1:0]     o_x_pc,
  output logic [n-1:0]     o_x_insn,
  output logic [n-1:0]     o_x_rs_data,
  output logic [n-1:0]     o_x_rt_data,
  output logic [2:0]       o_x_rs_sel,
  output logic [2:0]       o_x_rt_sel,
  output logic [2:0]       o_x_rd_sel,
  output logic             o_x_rd_we,
  output logic             o_x_is_load,
  output logic             o_x_is_store,
  output logic             o_x_is_branch,
  output logic             o_x_valid,
  output logic [ctl_w-1:0] o_x_ctl,
  output logic [1:0]       o_x_stall_code
);

  typedef struct packed {
    logic [n-1:0]     pc;
    logic [n-1:0]     insn;
    logic [n-1:0]     rs_data;
    logic [n-1:0]     rt_data;
    logic [2:0]       rs_sel;
    logic [2:0]       rt_sel;
    logic [2:0]       rd_sel;
    logic             rd_we;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             valid;
    logic [ctl_w-1:0] ctl;
    logic [1:0]       sc;
  } dx_t;

  dx_t x_q;
  dx_t nxt;

  logic [n-1:0] rs_val;
  logic [n-1:0] rt_val;
  logic         dep;
  logic         luse;

  assign o_rs_sel = i_d_rs_sel;
  assign o_rt_sel = i_d_rt_sel;

  assign rs_val = (i_w_rd_we && i_w_rd_sel == i_d_rs_sel)
                  ? i_w_wdata : i_rs_data;
  assign rt_val = (i_w_rd_we && i_w_rd_sel == i_d_rt_sel)
                  ? i_w_wdata : i_rt_data;

  // Store data is exempt: M-stage bypass delivers it in time.
  // Branches depend on the NZP bits the load sets.
  assign dep = (i_d_rs_re && i_d_rs_sel == x_q.rd_sel)
             | (i_d_rt_re && i_d_rt_sel == x_q.rd_sel
                && !i_d_is_store)
             | i_d_is_branch;

  assign luse = i_d_valid && x_q.valid && x_q.is_load
             && x_q.rd_we && dep;

  assign o_stall = luse && !i_flush;

  always_comb begin
    nxt = '0;
    if (i_flush) begin
      nxt.sc = 2'd2;
    end else if (luse) begin
      nxt.sc = 2'd3;
    end else begin
      nxt.pc        = i_d_pc;
      nxt.insn      = i_d_insn;
      nxt.rs_data   = rs_val;
      nxt.rt_data   = rt_val;
      nxt.rs_sel    = i_d_rs_sel;
      nxt.rt_sel    = i_d_rt_sel;
      nxt.rd_sel    = i_d_rd_sel;
      nxt.rd_we     = i_d_rd_we;
      nxt.is_load   = i_d_is_load;
      nxt.is_store  = i_d_is_store;
      nxt.is_branch = i_d_is_branch;
      nxt.valid     = i_d_valid;
      nxt.ctl       = i_d_ctl;
      nxt.sc        = i_d_stall_code;
    end
  end

  always_ff @(posedge clk) begin
    if (gwe) begin
      if (rst) begin
        x_q    <= '0;
        x_q.sc <= 2'd2;
      end else begin
        x_q <= nxt;
      end
    end
  end

  assign o_x_pc         = x_q.pc;
  assign o_x_insn       = x_q.insn;
  assign o_x_rs_data    = x_q.rs_data;
  assign o_x_rt_data    = x_q.rt_data;
  assign o_x_rs_sel     = x_q.rs_sel;
  assign o_x_rt_sel     = x_q.rt_sel;
  assign o_x_rd_sel     = x_q.rd_sel;
  assign o_x_rd_we      = x_q.rd_we;
  assign o_x_is_load    = x_q.is_load;
  assign o_x_is_store   = x_q.is_store;
  assign o_x_is_branch  = x_q.is_branch;
  assign o_x_valid      = x_q.valid;
  assign o_x_ctl        = x_q.ctl;
  assign o_x_stall_code = x_q.sc;

endmodule

// File: tb/tb_lc4_dx_stage.sv
// Directed self-checking bench for lc4_dx_stage.
// Linear step sequence with immediate assertions on each observation.
module tb_lc4_dx_stage;

  localparam int n     = 16;
  localparam int ctl_w = 16;

  logic             clk = 1'b0;
  logic             rst, gwe;
  logic [n-1:0]     d_pc, d_insn;
  logic             d_valid;
  logic [1:0]       d_sc;
  logic [2:0]       d_rs, d_rt, d_rd;
  logic             d_rs_re, d_rt_re, d_rd_we;
  logic             d_ld, d_st, d_br;
  logic [ctl_w-1:0] d_ctl;
  logic [2:0]       rs_sel, rt_sel;
  logic [n-1:0]     rs_data, rt_data;
  logic [2:0]       w_rd;
  logic             w_we;
  logic [n-1:0]     w_data;
  logic             flush;
  logic             stall;
  logic [n-1:0]     x_pc, x_insn, x_rs_data, x_rt_data;
  logic [2:0]       x_rs, x_rt, x_rd;
  logic             x_rd_we, x_ld, x_st, x_br, x_valid;
  logic [ctl_w-1:0] x_ctl;
  logic [1:0]       x_sc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lc4_dx_stage #(.n(n), .ctl_w(ctl_w)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_d_pc(d_pc), .i_d_insn(d_insn),
    .i_d_valid(d_valid), .i_d_stall_code(d_sc),
    .i_d_rs_sel(d_rs), .i_d_rt_sel(d_rt), .i_d_rd_sel(d_rd),
    .i_d_rs_re(d_rs_re), .i_d_rt_re(d_rt_re), .i_d_rd_we(d_rd_we),
    .i_d_is_load(d_ld), .i_d_is_store(d_st), .i_d_is_branch(d_br),
    .i_d_ctl(d_ctl),
    .o_rs_sel(rs_sel), .o_rt_sel(rt_sel),
    .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_w_rd_sel(w_rd), .i_w_rd_we(w_we), .i_w_wdata(w_data),
    .i_flush(flush), .o_stall(stall),
    .o_x_pc(x_pc), .o_x_insn(x_insn),
    .o_x_rs_data(x_rs_data), .o_x_rt_data(x_rt_data),
    .o_x_rs_sel(x_rs), .o_x_rt_sel(x_rt), .o_x_rd_sel(x_rd),
    .o_x_rd_we(x_rd_we), .o_x_is_load(x_ld),
    .o_x_is_store(x_st), .o_x_is_branch(x_br),
    .o_x_valid(x_valid), .o_x_ctl(x_ctl),
    .o_x_stall_code(x_sc)
  );

  task automatic chk(input string tag,
                     input logic [n-1:0] obs,
                     input logic [n-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_d();
    d_pc = '0; d_insn = '0; d_valid = 1'b0; d_sc = 2'd0;
    d_rs = '0; d_rt = '0; d_rd = '0;
    d_rs_re = 1'b0; d_rt_re = 1'b0; d_rd_we = 1'b0;
    d_ld = 1'b0; d_st = 1'b0; d_br = 1'b0; d_ctl = '0;
  endtask

  task automatic set_add(input logic [n-1:0] pc,
                         input logic [2:0] rs,
                         input logic [2:0] rt,
                         input logic [2:0] rd);
    clr_d();
    d_pc = pc; d_insn = 16'h1000 | pc; d_valid = 1'b1;
    d_rs = rs; d_rt = rt; d_rd = rd;
    d_rs_re = 1'b1; d_rt_re = 1'b1; d_rd_we = 1'b1;
    d_ctl = 16'h00A5;
  endtask

  task automatic set_ldr(input logic [n-1:0] pc,
                         input logic [2:0] rd);
    clr_d();
    d_pc = pc; d_insn = 16'h6000 | pc; d_valid = 1'b1;
    d_rs = 3'd1; d_rd = rd; d_rs_re = 1'b1;
    d_rd_we = 1'b1; d_ld = 1'b1;
  endtask

  initial begin
    clr_d();
    rst = 1'b1; gwe = 1'b1; flush = 1'b0;
    rs_data = '0; rt_data = '0;
    w_rd = '0; w_we = 1'b0; w_data = '0;
    #1;

    step();
    chk("rst_valid", 16'(x_valid), 16'd0);
    chk("rst_sc", 16'(x_sc), 16'd2);
    chk("rst_pc", x_pc, 16'd0);
    chk("rst_insn", x_insn, 16'd0);
    chk("rst_rs_data", x_rs_data, 16'd0);
    chk("rst_rd_sel", 16'(x_rd), 16'd0);

    rst = 1'b0;
    set_add(16'h0100, 3'd1, 3'd2, 3'd3);
    rs_data = 16'h0011; rt_data = 16'h0022;
    #1;
    chk("rs_sel_comb", 16'(rs_sel), 16'd1);
    chk("rt_sel_comb", 16'(rt_sel), 16'd2);
    chk("pass_stall", 16'(stall), 16'd0);
    step();
    chk("pass_rs_data", x_rs_data, 16'h0011);
    chk("pass_rt_data", x_rt_data, 16'h0022);
    chk("pass_rd_sel", 16'(x_rd), 16'd3);
    chk("pass_sc", 16'(x_sc), 16'd0);
    chk("pass_valid", 16'(x_valid), 16'd1);
    chk("pass_pc", x_pc, 16'h0100);
    chk("pass_ctl", x_ctl, 16'h00A5);

    rst = 1'b1; gwe = 1'b0;
    step();
    chk("rst_nogwe_valid", 16'(x_valid), 16'd1);
    chk("rst_nogwe_pc", x_pc, 16'h0100);
    rst = 1'b0; gwe = 1'b1;

    w_we = 1'b1; w_rd = 3'd2; w_data = 16'hBEEF;
    step();
    chk("byp_rt", x_rt_data, 16'hBEEF);
    chk("byp_rs_nohit", x_rs_data, 16'h0011);

    set_add(16'h0104, 3'd0, 3'd2, 3'd3);
    w_rd = 3'd0; w_data = 16'h1234;
    step();
    chk("byp_r0", x_rs_data, 16'h1234);
    chk("byp_r0_rt", x_rt_data, 16'h0022);
    w_we = 1'b0;

    set_ldr(16'h0200, 3'd4);
    step();
    chk("ldr_in_x", 16'(x_ld), 16'd1);
    set_add(16'h0202, 3'd4, 3'd5, 3'd6);
    #1;
    chk("luse_stall", 16'(stall), 16'd1);
    gwe = 1'b0;
    step();
    chk("nogwe_stall", 16'(stall), 16'd1);
    chk("nogwe_hold_ld", 16'(x_ld), 16'd1);
    gwe = 1'b1;
    step();
    chk("luse_bub_valid", 16'(x_valid), 16'd0);
    chk("luse_bub_sc", 16'(x_sc), 16'd3);
    chk("luse_bub_pc", x_pc, 16'd0);
    chk("luse_bub_rd_we", 16'(x_rd_we), 16'd0);
    chk("luse_drop", 16'(stall), 16'd0);
    step();
    chk("luse_adv_pc", x_pc, 16'h0202);
    chk("luse_adv_valid", 16'(x_valid), 16'd1);
    chk("luse_adv_sc", 16'(x_sc), 16'd0);

    set_ldr(16'h0210, 3'd4);
    step();
    clr_d();
    d_pc = 16'h0212; d_valid = 1'b1;
    d_rs = 3'd5; d_rt = 3'd4;
    d_rs_re = 1'b1; d_rt_re = 1'b1; d_st = 1'b1;
    #1;
    chk("store_nostall", 16'(stall), 16'd0);
    d_st = 1'b0;
    #1;
    chk("rt_dep_stall", 16'(stall), 16'd1);

    clr_d();
    d_pc = 16'h0214; d_valid = 1'b1; d_br = 1'b1;
    #1;
    chk("branch_stall", 16'(stall), 16'd1);
    flush = 1'b1;
    #1;
    chk("flush_nostall", 16'(stall), 16'd0);
    step();
    chk("flush_valid", 16'(x_valid), 16'd0);
    chk("flush_sc", 16'(x_sc), 16'd2);
    chk("flush_rd_we", 16'(x_rd_we), 16'd0);
    chk("flush_pc", x_pc, 16'd0);
    flush = 1'b0;

    set_ldr(16'h0300, 3'd4);
    step();
    set_add(16'h0302, 3'd4, 3'd4, 3'd1);
    d_valid = 1'b0; d_sc = 2'd2;
    #1;
    chk("inv_nostall", 16'(stall), 16'd0);
    step();
    chk("inv_valid", 16'(x_valid), 16'd0);
    chk("inv_sc", 16'(x_sc), 16'd2);
    chk("inv_pc", x_pc, 16'h0302);

    set_ldr(16'h0400, 3'd2);
    step();
    set_add(16'h0402, 3'd2, 3'd0, 3'd3);
    #1;
    chk("mid_stall", 16'(stall), 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 16'(x_valid), 16'd0);
    chk("mid_rst_sc", 16'(x_sc), 16'd2);
    chk("mid_rst_nostall", 16'(stall), 16'd0);
    step();
    chk("mid_rst_adv", x_pc, 16'h0402);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
